// File: rtl/sram_rd_sched.sv
// Round-robin SRAM read scheduler: packet-locked arbitration over NUM_PORTS requesters, with the
// returned data steered back by a tag pipeline. Optional stall counter under SRAM_RD_SCHED_STAT_EN.
module sram_rd_sched #(
   parameter int unsigned NUM_PORTS = 16,
   parameter int unsigned ADDR_W    = 17,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        req,
   input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
   input  logic [NUM_PORTS-1:0]        req_last,
   output logic [NUM_PORTS-1:0]        grant,
   output logic                        enb,
   output logic [ADDR_W-1:0]           addrb,
   input  logic [DATA_W-1:0]           doutb,
   output logic [NUM_PORTS-1:0]        rd_vld,
   output logic [DATA_W-1:0]           rd_data,
   output logic                        rd_last
`ifdef SRAM_RD_SCHED_STAT_EN
   ,
   output logic [15:0]                 stall_cnt
`endif
);

   localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic {StIdle, StLock} state_e;

   state_e                state_q;
   logic [PW-1:0]         ptr_q;
   logic [PW-1:0]         owner_q;

   logic                  gnt_any;
   logic [PW-1:0]         gnt_idx;
   logic [PW-1:0]         cand;
   logic [PW-1:0]         nxt_ptr;
   logic                  gnt_last;
   logic [ADDR_W-1:0]     gnt_addr;

   logic                  enb_q;
   logic [ADDR_W-1:0]     addrb_q;
   logic [NUM_PORTS-1:0]  iss_vld_q;
   logic                  iss_last_q;
   logic [NUM_PORTS-1:0]  pipe_vld_q  [RD_LAT];
   logic                  pipe_last_q [RD_LAT];
   logic [NUM_PORTS-1:0]  rd_vld_q;
   logic [DATA_W-1:0]     rd_data_q;
   logic                  rd_last_q;

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      if (!rst) begin
         if (state_q == StIdle) begin
            // Scan from the far end so the lowest offset from ptr wins without a break.
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
               cand = PW'((int'(ptr_q) + i) % NUM_PORTS);
               if (req[cand]) begin
                  gnt_any = 1'b1;
                  gnt_idx = cand;
               end
            end
         end else if (req[owner_q]) begin
            gnt_any = 1'b1;
            gnt_idx = owner_q;
         end
      end
   end

   always_comb begin
      grant    = gnt_any ? (NUM_PORTS'(1) << gnt_idx) : '0;
      gnt_last = req_last[gnt_idx];
      gnt_addr = req_addr[int'(gnt_idx) * ADDR_W +: ADDR_W];
      nxt_ptr  = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         owner_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (gnt_any) begin
                  if (gnt_last) begin
                     ptr_q <= nxt_ptr;
                  end else begin
                     state_q <= StLock;
                     owner_q <= gnt_idx;
                  end
               end
            end
            StLock: begin
               if (gnt_any && gnt_last) begin
                  state_q <= StIdle;
                  ptr_q   <= nxt_ptr;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Issue stage lines up with enb; the tag pipeline then tracks the SRAM latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         enb_q      <= 1'b0;
         addrb_q    <= '0;
         iss_vld_q  <= '0;
         iss_last_q <= 1'b0;
         for (int k = 0; k < RD_LAT; k++) begin
            pipe_vld_q[k]  <= '0;
            pipe_last_q[k] <= 1'b0;
         end
         rd_vld_q   <= '0;
         rd_data_q  <= '0;
         rd_last_q  <= 1'b0;
      end else begin
         enb_q      <= gnt_any;
         if (gnt_any) begin
            addrb_q <= gnt_addr;
         end
         iss_vld_q  <= grant;
         iss_last_q <= gnt_any & gnt_last;
         pipe_vld_q[0]  <= iss_vld_q;
         pipe_last_q[0] <= iss_last_q;
         for (int k = 1; k < RD_LAT; k++) begin
            pipe_vld_q[k]  <= pipe_vld_q[k-1];
            pipe_last_q[k] <= pipe_last_q[k-1];
         end
         rd_vld_q  <= pipe_vld_q[RD_LAT-1];
         rd_last_q <= pipe_last_q[RD_LAT-1];
         if (|pipe_vld_q[RD_LAT-1]) begin
            rd_data_q <= doutb;
         end
      end
   end

   assign enb     = enb_q;
   assign addrb   = addrb_q;
   assign rd_vld  = rd_vld_q;
   assign rd_data = rd_data_q;
   assign rd_last = rd_last_q;

`ifdef SRAM_RD_SCHED_STAT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if ((|req) && !gnt_any && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sram_rd_sched.sv
// Directed self-checking bench for sram_rd_sched (default parameters, RD_LAT=1).
module tb_sram_rd_sched;

   localparam int NP = 16;
   localparam int AW = 17;
   localparam int DW = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0]     req;
   logic [AW*NP-1:0]  req_addr;
   logic [NP-1:0]     req_last;
   logic [NP-1:0]     grant;
   logic              enb;
   logic [AW-1:0]     addrb;
   logic [DW-1:0]     doutb;
   logic [NP-1:0]     rd_vld;
   logic [DW-1:0]     rd_data;
   logic              rd_last;
`ifdef SRAM_RD_SCHED_STAT_EN
   logic [15:0]       stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   sram_rd_sched #(
      .NUM_PORTS(NP),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .RD_LAT   (1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .req_addr(req_addr),
      .req_last(req_last),
      .grant   (grant),
      .enb     (enb),
      .addrb   (addrb),
      .doutb   (doutb),
      .rd_vld  (rd_vld),
      .rd_data (rd_data),
      .rd_last (rd_last)
`ifdef SRAM_RD_SCHED_STAT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {16'hC0DE, 31'd0, a};
   endfunction

   // One-cycle-latency SRAM model
   always @(posedge clk) begin
      if (enb) doutb <= mem_word(addrb);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int p, input int a);
      req_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic do_reset(input int n);
      rst      = 1'b1;
      req      = '0;
      req_last = '0;
      repeat (n) tick();
      rst      = 1'b0;
   endtask

   logic [NP-1:0] lk_g [9] = '{16'h08, 16'h08, 16'h08, 16'h08, 16'h80, 16'h0, 16'h0, 16'h0, 16'h0};
   logic [NP-1:0] lk_v [9] = '{16'h0, 16'h0, 16'h0, 16'h08, 16'h08, 16'h08, 16'h08, 16'h80, 16'h0};
   logic          lk_l [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   logic [NP-1:0] gp_r [7] = '{16'h24, 16'h20, 16'h20, 16'h24, 16'h24, 16'h20, 16'h00};
   logic [NP-1:0] gp_l [7] = '{16'h20, 16'h20, 16'h20, 16'h20, 16'h24, 16'h20, 16'h00};
   logic [NP-1:0] gp_g [7] = '{16'h04, 16'h00, 16'h00, 16'h04, 16'h04, 16'h20, 16'h00};
   logic          gp_e [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

`ifdef SRAM_RD_SCHED_STAT_EN
   logic [NP-1:0] st_r [7] = '{16'h12, 16'h10, 16'h10, 16'h10, 16'h12, 16'h10, 16'h00};
   logic [NP-1:0] st_l [7] = '{16'h10, 16'h10, 16'h10, 16'h10, 16'h12, 16'h10, 16'h00};
   logic [NP-1:0] st_g [7] = '{16'h02, 16'h00, 16'h00, 16'h00, 16'h02, 16'h10, 16'h00};
   logic [15:0]   st_c [7] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3};
`endif

   initial begin
      rst      = 1'b1;
      req      = 16'h0001;
      req_last = 16'h0001;
      req_addr = '0;
      set_addr(0, 5);

      // Reset, then a single-word read from port 0
      tick();
      @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_enb", enb, 0);
      check("rst_addrb", addrb, 0);
      check("rst_rd_vld", rd_vld, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_rd_last", rd_last, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("first_grant", grant, 16'h0001);
      tick();
      req = '0;
      @(negedge clk);
      check("first_enb", enb, 1);
      check("first_addrb", addrb, 5);
      check("idle_grant", grant, 0);
      tick();
      @(negedge clk);
      check("idle_enb", enb, 0);
      check("hold_addrb", addrb, 5);
      check("early_rd_vld", rd_vld, 0);
      tick();
      @(negedge clk);
      check("first_rd_vld", rd_vld, 16'h0001);
      check("first_rd_data", rd_data, mem_word(AW'(5)));
      check("first_rd_last", rd_last, 1);
      tick();
      @(negedge clk);
      check("first_rd_done", rd_vld, 0);

      // Round robin over all ports with single-word packets, including wrap
      tick();
      do_reset(1);
      for (int p = 0; p < NP; p++) set_addr(p, 100 + p);
      req      = 16'hFFFF;
      req_last = 16'hFFFF;
      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         check("rr_grant", grant, 16'h1 << (k % NP));
         if (k >= 1) begin
            check("rr_enb", enb, 1);
            check("rr_addrb", addrb, 100 + ((k - 1) % NP));
         end
         tick();
      end
      req = '0;

      // Port 3 sends a 4-word packet while port 7 waits
      do_reset(1);
      for (int c = 0; c < 9; c++) begin
         req      = (c < 4) ? 16'h0088 : ((c == 4) ? 16'h0080 : 16'h0000);
         req_last = (c == 3) ? 16'h0088 : 16'h0080;
         set_addr(3, 200 + c);
         @(negedge clk);
         check("lock_grant", grant, lk_g[c]);
         check("lock_rd_vld", rd_vld, lk_v[c]);
         check("lock_rd_last", rd_last, lk_l[c]);
         if (c == 3) check("lock_rd_data", rd_data, mem_word(AW'(200)));
         tick();
      end

      // Owner port 2 pauses mid-packet while port 5 requests
      do_reset(1);
      for (int c = 0; c < 7; c++) begin
         req      = gp_r[c];
         req_last = gp_l[c];
         @(negedge clk);
         check("gap_grant", grant, gp_g[c]);
         check("gap_enb", enb, gp_e[c]);
         tick();
      end

      // Reset one cycle after a grant to port 9 discards the read
      do_reset(1);
      set_addr(9, 77);
      req      = 16'h0200;
      req_last = 16'h0000;
      @(negedge clk);
      check("mf_grant", grant, 16'h0200);
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("mf_rst_grant", grant, 0);
      tick();
      rst = 1'b0;
      req = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("mf_rd_vld", rd_vld, 0);
         if (c == 0) begin
            check("mf_enb", enb, 0);
            check("mf_addrb", addrb, 0);
         end
         tick();
      end
      req      = 16'h0201;
      req_last = 16'h0201;
      @(negedge clk);
      check("mf_idle_ptr0", grant, 16'h0001);
      tick();
      req = 16'h0200;
      @(negedge clk);
      check("mf_after", grant, 16'h0200);
      tick();
      req = '0;

`ifdef SRAM_RD_SCHED_STAT_EN
      // Port 1 locked and idle for 3 cycles while port 4 requests
      do_reset(1);
      @(negedge clk);
      check("st_rst", stall_cnt, 0);
      for (int c = 0; c < 7; c++) begin
         req      = st_r[c];
         req_last = st_l[c];
         @(negedge clk);
         check("st_grant", grant, st_g[c]);
         check("st_cnt", stall_cnt, st_c[c]);
         tick();
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
